// File: rtl/bank_state_tracker_pkg.sv
// Shared command-word layout, DDR command encodings and error-flag indices
// for the per-rank, per-bank DRAM state tracker.
package bank_state_tracker_pkg;

  // Command-word field positions (row and bank sit at the bottom of the word).
  localparam int CMD_DDR_BIT = 31;
  localparam int CMD_CS_LSB  = 27;
  localparam int CMD_RAS_BIT = 26;
  localparam int CMD_CAS_BIT = 25;
  localparam int CMD_WE_BIT  = 24;
  localparam int CMD_A10_BIT = 10;

  // {RAS, CAS, WE} encodings of the commands the tracker reacts to.
  localparam logic [2:0] RCW_ACT = 3'b011;
  localparam logic [2:0] RCW_PRE = 3'b010;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_REF = 3'b001;

  localparam int ERR_WIDTH       = 3;
  localparam int ERR_ACT_OPEN    = 0;
  localparam int ERR_RDWR_CLOSED = 1;
  localparam int ERR_REF_OPEN    = 2;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_RD,
    CMD_WR,
    CMD_REF
  } cmd_e;

  // Per-bank load strobes produced by the top-level demux.
  typedef struct packed {
    logic act;
    logic pre;
    logic pre_row;
  } bank_ld_t;

  function automatic cmd_e decode_cmd(input logic [2:0] rcw);
    case (rcw)
      RCW_ACT: return CMD_ACT;
      RCW_PRE: return CMD_PRE;
      RCW_RD:  return CMD_RD;
      RCW_WR:  return CMD_WR;
      RCW_REF: return CMD_REF;
      default: return CMD_NOP;
    endcase
  endfunction

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_state_tracker_bank_timer.sv
// One bank's open flag, last row, tRCD/tRP/tRAS countdowns and saturating
// ACT counter; loaded by the top-level command demux.
module bank_timer
  import bank_state_tracker_pkg::*;
#(
  parameter int ROW_WIDTH     = 16,
  parameter int CNT_WIDTH     = 5,
  parameter int T_RCD         = 4,
  parameter int T_RP          = 4,
  parameter int T_RAS         = 10,
  parameter int ACT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  bank_ld_t                 ld_i,
  input  logic                     cnt_clr_i,
  input  logic [ROW_WIDTH-1:0]     row_i,
  output logic                     open_o,
  output logic [ROW_WIDTH-1:0]     row_o,
  output logic                     rcd_done_o,
  output logic                     rp_done_o,
  output logic                     ras_done_o,
  output logic [ACT_CNT_WIDTH-1:0] act_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] RCD_LOAD = CNT_WIDTH'(T_RCD);
  localparam logic [CNT_WIDTH-1:0] RP_LOAD  = CNT_WIDTH'(T_RP);
  localparam logic [CNT_WIDTH-1:0] RAS_LOAD = CNT_WIDTH'(T_RAS);

  logic                     open_q, open_d;
  logic [ROW_WIDTH-1:0]     row_q, row_d;
  logic [CNT_WIDTH-1:0]     rcd_q, rcd_d;
  logic [CNT_WIDTH-1:0]     rp_q, rp_d;
  logic [CNT_WIDTH-1:0]     ras_q, ras_d;
  logic [ACT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACT_CNT_WIDTH-1:0] cnt_base;

  // A reload always beats the running decrement.
  function automatic logic [CNT_WIDTH-1:0] next_count(
    input logic                 load,
    input logic [CNT_WIDTH-1:0] reload,
    input logic [CNT_WIDTH-1:0] cur
  );
    if (load) return reload;
    if (cur != '0) return cur - 1'b1;
    return cur;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    rcd_d  = next_count(ld_i.act, RCD_LOAD, rcd_q);
    ras_d  = next_count(ld_i.act, RAS_LOAD, ras_q);
    rp_d   = next_count(ld_i.pre, RP_LOAD, rp_q);

    if (ld_i.act) begin
      open_d = 1'b1;
      row_d  = row_i;
    end else if (ld_i.pre) begin
      open_d = 1'b0;
      if (ld_i.pre_row) row_d = row_i;
    end

    cnt_base = cnt_clr_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (ld_i.act && (cnt_base != '1)) cnt_d = cnt_base + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all banks update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= 1'b0;
      row_q  <= '0;
      rcd_q  <= '0;
      rp_q   <= '0;
      ras_q  <= '0;
      cnt_q  <= '0;
    end else begin
      open_q <= open_d;
      row_q  <= row_d;
      rcd_q  <= rcd_d;
      rp_q   <= rp_d;
      ras_q  <= ras_d;
      cnt_q  <= cnt_d;
    end
  end

  assign open_o     = open_q;
  assign row_o      = row_q;
  assign rcd_done_o = (rcd_q == '0);
  assign rp_done_o  = (rp_q == '0);
  assign ras_done_o = (ras_q == '0);
  assign act_cnt_o  = cnt_q;

endmodule

// File: rtl/bank_state_tracker.sv
// DRAM bank state tracker: decodes the CMD_RECV stream, demuxes it onto a
// rank x bank grid of bank_timer instances, flags protocol errors, answers queries.
module bank_state_tracker
  import bank_state_tracker_pkg::*;
#(
  parameter int ROW_WIDTH     = 16,
  parameter int BANK_WIDTH    = 3,
  parameter int CS_WIDTH      = 1,
  parameter int CNT_WIDTH     = 5,
  parameter int T_RCD         = 4,
  parameter int T_RP          = 4,
  parameter int T_RAS         = 10,
  parameter int ACT_CNT_WIDTH = 16,
  parameter bit TRACK_MNT     = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         instr,
  input  logic                                is_app,
  input  logic                                is_mnt,
  input  logic                                cnt_clr,
  input  logic                                err_clr,
  input  logic [min1_clog2(CS_WIDTH)-1:0]     maint_rank,
  input  logic [BANK_WIDTH-1:0]               maint_bank,
  output logic                                maint_open,
  output logic [ROW_WIDTH-1:0]                maint_row,
  output logic                                maint_act_ok,
  output logic                                maint_rdwr_ok,
  output logic                                maint_pre_ok,
  output logic [ACT_CNT_WIDTH-1:0]            maint_act_cnt,
  output logic [ERR_WIDTH-1:0]                protocol_err
);

  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  localparam int RANK_W    = min1_clog2(CS_WIDTH);
  localparam int CNT_LIMIT = (1 << CNT_WIDTH) - 1;

  if (T_RCD > CNT_LIMIT || T_RP > CNT_LIMIT || T_RAS > CNT_LIMIT ||
      T_RCD < 0 || T_RP < 0 || T_RAS < 0) begin : g_bad_timing
    $error("bank_state_tracker: T_RCD/T_RP/T_RAS must fit in CNT_WIDTH bits");
  end
  if (ROW_WIDTH + BANK_WIDTH > CMD_WE_BIT || CMD_CS_LSB + CS_WIDTH > CMD_DDR_BIT) begin : g_bad_layout
    $error("bank_state_tracker: row/bank/CS fields overlap command bits");
  end

  logic                  cmd_valid;
  cmd_e                  cmd;
  logic [CS_WIDTH-1:0]   rank_sel;
  logic [BANK_WIDTH-1:0] cmd_bank;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic                  cmd_a10;
  logic                  instr_unused;

  assign cmd_valid = (is_app | (TRACK_MNT & is_mnt)) & instr[CMD_DDR_BIT];
  assign cmd       = cmd_valid ? decode_cmd({instr[CMD_RAS_BIT], instr[CMD_CAS_BIT], instr[CMD_WE_BIT]})
                               : CMD_NOP;
  // CS is active-low: every rank with a low bit is a target.
  assign rank_sel  = ~instr[CMD_CS_LSB +: CS_WIDTH];
  assign cmd_bank  = instr[ROW_WIDTH +: BANK_WIDTH];
  assign cmd_row   = instr[ROW_WIDTH-1:0];
  assign cmd_a10   = instr[CMD_A10_BIT];
  assign instr_unused = ^instr;

  logic                     bank_open [CS_WIDTH][NUM_BANKS];
  logic [ROW_WIDTH-1:0]     bank_row  [CS_WIDTH][NUM_BANKS];
  logic                     bank_rcd  [CS_WIDTH][NUM_BANKS];
  logic                     bank_rp   [CS_WIDTH][NUM_BANKS];
  logic                     bank_ras  [CS_WIDTH][NUM_BANKS];
  logic [ACT_CNT_WIDTH-1:0] bank_cnt  [CS_WIDTH][NUM_BANKS];

  for (genvar r = 0; r < CS_WIDTH; r++) begin : g_rank
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      bank_ld_t ld;
      logic     bank_hit;

      assign bank_hit   = rank_sel[r] && (cmd_bank == BANK_WIDTH'(b));
      assign ld.act     = bank_hit && (cmd == CMD_ACT);
      assign ld.pre     = rank_sel[r] && (cmd == CMD_PRE) && (cmd_a10 || (cmd_bank == BANK_WIDTH'(b)));
      assign ld.pre_row = !cmd_a10;

      bank_timer #(
        .ROW_WIDTH    (ROW_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .T_RCD        (T_RCD),
        .T_RP         (T_RP),
        .T_RAS        (T_RAS),
        .ACT_CNT_WIDTH(ACT_CNT_WIDTH)
      ) u_bank (
        .clk       (clk),
        .rst_ni    (rst),
        .ld_i      (ld),
        .cnt_clr_i (cnt_clr),
        .row_i     (cmd_row),
        .open_o    (bank_open[r][b]),
        .row_o     (bank_row[r][b]),
        .rcd_done_o(bank_rcd[r][b]),
        .rp_done_o (bank_rp[r][b]),
        .ras_done_o(bank_ras[r][b]),
        .act_cnt_o (bank_cnt[r][b])
      );
    end
  end

  logic [ERR_WIDTH-1:0] err_q, err_d, err_new;
  logic                 rank_any_open;

  // Errors are judged against pre-command state of every targeted rank.
  always_comb begin
    err_new       = '0;
    rank_any_open = 1'b0;
    for (int r = 0; r < CS_WIDTH; r++) begin
      rank_any_open = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) rank_any_open = rank_any_open | bank_open[r][b];
      if (rank_sel[r]) begin
        case (cmd)
          CMD_ACT:        if (bank_open[r][cmd_bank])  err_new[ERR_ACT_OPEN]    = 1'b1;
          CMD_RD, CMD_WR: if (!bank_open[r][cmd_bank]) err_new[ERR_RDWR_CLOSED] = 1'b1;
          CMD_REF:        if (rank_any_open)           err_new[ERR_REF_OPEN]    = 1'b1;
          default: ;
        endcase
      end
    end
    err_d = (err_clr ? '0 : err_q) | err_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else      err_q <= err_d;
  end

  assign protocol_err = err_q;

  // A rank index with no matching rank falls through to the reset-state answer.
  always_comb begin
    maint_open    = 1'b0;
    maint_row     = '0;
    maint_act_ok  = 1'b1;
    maint_rdwr_ok = 1'b0;
    maint_pre_ok  = 1'b1;
    maint_act_cnt = '0;
    for (int r = 0; r < CS_WIDTH; r++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (maint_rank == RANK_W'(r) && maint_bank == BANK_WIDTH'(b)) begin
          maint_open    = bank_open[r][b];
          maint_row     = bank_row[r][b];
          maint_act_ok  = !bank_open[r][b] && bank_rp[r][b];
          maint_rdwr_ok = bank_open[r][b] && bank_rcd[r][b];
          maint_pre_ok  = bank_ras[r][b];
          maint_act_cnt = bank_cnt[r][b];
        end
      end
    end
  end

endmodule

// File: tb/tb_bank_state_tracker.sv
// Randomized and directed bench for bank_state_tracker (2 ranks, 4-bit ACT
// counters) against an event-time reference model of the bank rules.
module tb_bank_state_tracker;
  import bank_state_tracker_pkg::*;

  localparam int ROW_W = 16, BANK_W = 3, CS_W = 2, ACW = 4, NB = 8;
  localparam int TRCD = 4, TRP = 4, TRAS = 10;
  localparam int CNT_MAX = (1 << ACW) - 1;
  localparam int QW = 1 + ROW_W + 3 + ACW + 3;
  localparam logic [2:0] E_ACT = 3'b011, E_PRE = 3'b010, E_RD = 3'b101, E_WR = 3'b100,
                         E_REF = 3'b001, E_NOP = 3'b111;

  logic              clk = 1'b0, rst = 1'b0;
  logic [31:0]       instr = '0;
  logic              is_app = 1'b0, is_mnt = 1'b0, cnt_clr = 1'b0, err_clr = 1'b0;
  logic [0:0]        maint_rank = '0;
  logic [BANK_W-1:0] maint_bank = '0;
  logic              maint_open, maint_act_ok, maint_rdwr_ok, maint_pre_ok;
  logic [ROW_W-1:0]  maint_row;
  logic [ACW-1:0]    maint_act_cnt;
  logic [2:0]        protocol_err;

  int n_tests = 0, n_fail = 0;

  bank_state_tracker #(.CS_WIDTH(CS_W), .ACT_CNT_WIDTH(ACW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .is_app(is_app), .is_mnt(is_mnt),
    .cnt_clr(cnt_clr), .err_clr(err_clr), .maint_rank(maint_rank), .maint_bank(maint_bank),
    .maint_open(maint_open), .maint_row(maint_row), .maint_act_ok(maint_act_ok),
    .maint_rdwr_ok(maint_rdwr_ok), .maint_pre_ok(maint_pre_ok),
    .maint_act_cnt(maint_act_cnt), .protocol_err(protocol_err)
  );

  always #20 clk = ~clk;

  // Reference model: state plus the edge index at which each timer was last started.
  bit               m_open [CS_W][NB];
  logic [ROW_W-1:0] m_row  [CS_W][NB];
  longint           m_rcd  [CS_W][NB];
  longint           m_rp   [CS_W][NB];
  longint           m_ras  [CS_W][NB];
  int               m_cnt  [CS_W][NB];
  logic [2:0]       m_err;
  longint           now = 0;

  function automatic void model_reset();
    for (int r = 0; r < CS_W; r++)
      for (int b = 0; b < NB; b++) begin
        m_open[r][b] = 0; m_row[r][b] = '0; m_cnt[r][b] = 0;
        m_rcd[r][b] = now - 1000; m_rp[r][b] = now - 1000; m_ras[r][b] = now - 1000;
      end
    m_err = '0;
  endfunction

  function automatic void model_apply(logic [31:0] ins, bit app, bit mnt, bit cclr, bit eclr);
    logic [2:0] rcw = {ins[CMD_RAS_BIT], ins[CMD_CAS_BIT], ins[CMD_WE_BIT]};
    int         bank = int'(ins[ROW_W +: BANK_W]);
    bit         a10 = ins[CMD_A10_BIT];
    logic [2:0] new_err = '0;
    bit         any_open;
    now++;
    if (cclr)
      for (int r = 0; r < CS_W; r++) for (int b = 0; b < NB; b++) m_cnt[r][b] = 0;
    if ((app || mnt) && ins[31]) begin
      for (int r = 0; r < CS_W; r++) begin
        if (ins[CMD_CS_LSB + r] == 1'b0) begin
          case (rcw)
            E_ACT: begin
              if (m_open[r][bank]) new_err[0] = 1'b1;
              m_open[r][bank] = 1; m_row[r][bank] = ins[ROW_W-1:0];
              m_rcd[r][bank] = now; m_ras[r][bank] = now;
              m_cnt[r][bank] = (m_cnt[r][bank] < CNT_MAX) ? m_cnt[r][bank] + 1 : CNT_MAX;
            end
            E_PRE:
              for (int b = 0; b < NB; b++)
                if (a10 || b == bank) begin
                  m_open[r][b] = 0; m_rp[r][b] = now;
                  if (!a10) m_row[r][b] = ins[ROW_W-1:0];
                end
            E_RD, E_WR: if (!m_open[r][bank]) new_err[1] = 1'b1;
            E_REF: begin
              any_open = 0;
              for (int b = 0; b < NB; b++) any_open |= m_open[r][b];
              if (any_open) new_err[2] = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
    m_err = (eclr ? 3'b000 : m_err) | new_err;
  endfunction

  function automatic logic [QW-1:0] expect_q(int r, int b);
    bit act_ok  = !m_open[r][b] && (now - m_rp[r][b] >= TRP);
    bit rdwr_ok = m_open[r][b] && (now - m_rcd[r][b] >= TRCD);
    bit pre_ok  = (now - m_ras[r][b] >= TRAS);
    return {m_open[r][b], m_row[r][b], act_ok, rdwr_ok, pre_ok, ACW'(m_cnt[r][b]), m_err};
  endfunction

  function automatic logic [QW-1:0] observe();
    return {maint_open, maint_row, maint_act_ok, maint_rdwr_ok, maint_pre_ok, maint_act_cnt, protocol_err};
  endfunction

  function automatic logic [31:0] mk(logic [2:0] rcw, logic [1:0] cs, int bank, logic [15:0] row);
    logic [31:0] ins = '0;
    ins[31] = 1'b1;
    ins[CMD_CS_LSB +: CS_W] = cs;
    {ins[CMD_RAS_BIT], ins[CMD_CAS_BIT], ins[CMD_WE_BIT]} = rcw;
    ins[ROW_W +: BANK_W] = BANK_W'(bank);
    ins[ROW_W-1:0] = row;
    return ins;
  endfunction

  task automatic do_cycle(logic [31:0] ins, bit app = 1, bit mnt = 0, bit cclr = 0, bit eclr = 0);
    @(negedge clk);
    instr = ins; is_app = app; is_mnt = mnt; cnt_clr = cclr; err_clr = eclr;
    @(posedge clk);
    model_apply(ins, app, mnt, cclr, eclr);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < CS_W; r++)
      for (int b = 0; b < NB; b++) begin
        maint_rank = 1'(r); maint_bank = 3'(b); #1;
        n_tests++;
        if (observe() !== expect_q(r, b)) begin
          n_fail++; $display("FAIL reset r%0d b%0d: got %h expected %h", r, b, observe(), expect_q(r, b));
        end
      end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_act_timing();
    maint_rank = 0; maint_bank = 3;
    do_cycle(mk(E_ACT, 2'b10, 3, 16'h1234));
    for (int k = 0; k < 13; k++) begin
      n_tests++;
      if (observe() !== expect_q(0, 3)) begin
        n_fail++; $display("FAIL act_timing step%0d: got %h expected %h", k, observe(), expect_q(0, 3));
      end
      do_cycle(mk(E_NOP, 2'b10, 0, 16'h0));
    end
  endtask

  task automatic test_pre_window();
    maint_rank = 0; maint_bank = 3;
    do_cycle(mk(E_PRE, 2'b10, 3, 16'h0055));
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (observe() !== expect_q(0, 3)) begin
        n_fail++; $display("FAIL pre_window step%0d: got %h expected %h", k, observe(), expect_q(0, 3));
      end
      do_cycle((k == 1) ? mk(E_ACT, 2'b10, 3, 16'h0777) : mk(E_NOP, 2'b10, 0, 16'h0));
    end
  endtask

  task automatic test_errors();
    logic [31:0] seq [6];
    bit          clr [6];
    int          qb  [6];
    seq = '{mk(E_NOP, 2'b11, 0, 0), mk(E_ACT, 2'b10, 3, 16'h0999), mk(E_NOP, 2'b11, 0, 0),
            mk(E_NOP, 2'b11, 0, 0), mk(E_RD, 2'b10, 5, 0), mk(E_WR, 2'b10, 5, 0)};
    clr = '{1, 0, 0, 1, 0, 1};
    qb  = '{3, 3, 3, 3, 5, 5};
    for (int k = 0; k < 6; k++) begin
      do_cycle(seq[k], 1, 0, 0, clr[k]);
      maint_rank = 0; maint_bank = 3'(qb[k]); #1;
      n_tests++;
      if (observe() !== expect_q(0, qb[k])) begin
        n_fail++; $display("FAIL errors step%0d: got %h expected %h", k, observe(), expect_q(0, qb[k]));
      end
    end
  endtask

  task automatic test_prea_refresh();
    logic [31:0] seq [8];
    seq = '{mk(E_ACT, 2'b10, 1, 16'h0101), mk(E_ACT, 2'b10, 4, 16'h0404), mk(E_ACT, 2'b10, 7, 16'h0707),
            mk(E_PRE, 2'b10, 0, 16'h0400), mk(E_REF, 2'b10, 0, 0), mk(E_ACT, 2'b10, 2, 16'h0202),
            mk(E_REF, 2'b10, 0, 0), mk(E_NOP, 2'b11, 0, 0)};
    do_cycle(mk(E_PRE, 2'b00, 0, 16'h0400), 1, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      do_cycle(seq[k]);
      for (int b = 0; b < NB; b++) begin
        maint_rank = 0; maint_bank = 3'(b); #1;
        n_tests++;
        if (observe() !== expect_q(0, b)) begin
          n_fail++; $display("FAIL prea_refresh step%0d b%0d: got %h expected %h", k, b, observe(), expect_q(0, b));
        end
      end
    end
  endtask

  task automatic test_act_counter();
    maint_rank = 0; maint_bank = 0;
    do_cycle(mk(E_NOP, 2'b11, 0, 0), 1, 0, 1, 1);
    for (int k = 0; k < 26; k++) begin
      case (k)
        20:      do_cycle(mk(E_ACT, 2'b10, 0, 16'h00AA), 1, 0, 1, 0);
        21:      do_cycle(mk(E_NOP, 2'b11, 0, 0), 1, 0, 1, 0);
        22:      do_cycle(mk(E_ACT, 2'b10, 0, 16'h00BB), 1, 1, 0, 0);
        23:      do_cycle(mk(E_ACT, 2'b10, 0, 16'h00CC), 0, 1, 0, 0);
        24:      do_cycle(mk(E_ACT, 2'b10, 0, 16'h00DD), 0, 0, 0, 0);
        25:      do_cycle(mk(E_ACT, 2'b10, 0, 16'h00EE) & 32'h7FFF_FFFF, 1, 0, 0, 0);
        default: do_cycle(mk(E_ACT, 2'b10, 0, 16'(k)));
      endcase
      n_tests++;
      if (observe() !== expect_q(0, 0)) begin
        n_fail++; $display("FAIL act_counter step%0d: got %h expected %h", k, observe(), expect_q(0, 0));
      end
    end
  endtask

  task automatic test_broadcast_async_reset();
    do_cycle(mk(E_ACT, 2'b00, 6, 16'hBEEF), 1, 0, 0, 1);
    do_cycle(mk(E_NOP, 2'b11, 0, 0));
    for (int r = 0; r < CS_W; r++) begin
      maint_rank = 1'(r); maint_bank = 6; #1;
      n_tests++;
      if (observe() !== expect_q(r, 6)) begin
        n_fail++; $display("FAIL broadcast r%0d: got %h expected %h", r, observe(), expect_q(r, 6));
      end
    end
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    #1;
    for (int r = 0; r < CS_W; r++) begin
      maint_rank = 1'(r); maint_bank = 6; #1;
      n_tests++;
      if (observe() !== expect_q(r, 6)) begin
        n_fail++; $display("FAIL async_reset r%0d: got %h expected %h", r, observe(), expect_q(r, 6));
      end
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_random();
    logic [2:0]  rcw_tab [8] = '{E_ACT, E_ACT, E_PRE, E_RD, E_WR, E_REF, E_NOP, 3'b000};
    logic [31:0] ins;
    logic [15:0] row;
    for (int k = 0; k < 250; k++) begin
      row = 16'($urandom);
      row[10] = ($urandom_range(0, 4) == 0);
      ins = mk(rcw_tab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), $urandom_range(0, 7), row);
      ins[31] = ($urandom_range(0, 9) != 0);
      do_cycle(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      for (int r = 0; r < CS_W; r++)
        for (int b = 0; b < NB; b++) begin
          maint_rank = 1'(r); maint_bank = 3'(b); #1;
          n_tests++;
          if (observe() !== expect_q(r, b)) begin
            n_fail++; $display("FAIL random cyc%0d r%0d b%0d: got %h expected %h", k, r, b, observe(), expect_q(r, b));
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_act_timing();
    test_pre_window();
    test_errors();
    test_prea_refresh();
    test_act_counter();
    test_broadcast_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_state_tracker.md
Name: bank_state_tracker

Overview:
- Per-rank, per-bank DRAM state tracker fed by the command stream from CMD_RECV. Tracks open/closed state and open row for every bank of every rank.
- Adds per-bank tRCD/tRP/tRAS readiness countdowns, saturating per-bank ACT counters for disturbance experiments, and sticky protocol-error detection.
- Queried by MAINT_HANDLR through a combinational lookup port.

Parameters:
- ROW_WIDTH, 16, row address bits (instr[ROW_WIDTH-1:0])
- BANK_WIDTH, 3, bank bits (instr[ROW_WIDTH +: BANK_WIDTH]); NUM_BANKS = 1<<BANK_WIDTH
- CS_WIDTH, 1, chip selects; one rank per CS bit
- CNT_WIDTH, 5, width of each timing countdown
- T_RCD, 4, ACT-to-RD/WR delay in clk cycles
- T_RP, 4, PRE-to-ACT delay in clk cycles
- T_RAS, 10, ACT-to-PRE delay in clk cycles
- ACT_CNT_WIDTH, 16, width of each per-bank ACT counter
- TRACK_MNT, 1, 1 = maintenance commands also update state; 0 = application commands only

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous assert, active-low
- instr  in  32  command word from CMD_RECV; instr[31]=1 marks a DDR command; CS/RAS/CAS/WE fields at the shared include offsets
- is_app  in  1  instr valid, application source
- is_mnt  in  1  instr valid, maintenance source
- cnt_clr  in  1  clear all ACT counters
- err_clr  in  1  clear sticky errors
- maint_rank  in  log2(CS_WIDTH) (min 1)  query rank
- maint_bank  in  BANK_WIDTH  query bank
- maint_open  out  1  queried bank open
- maint_row  out  ROW_WIDTH  last ACT/PRE row of queried bank
- maint_act_ok  out  1  bank closed and tRP countdown = 0
- maint_rdwr_ok  out  1  bank open and tRCD countdown = 0
- maint_pre_ok  out  1  tRAS countdown = 0
- maint_act_cnt  out  ACT_CNT_WIDTH  ACT count of queried bank
- protocol_err  out  3  sticky flags: [0] ACT to open bank, [1] RD/WR to closed bank, [2] REF with any bank open in target rank

Behaviour:
- Command qualification: valid = is_app | (TRACK_MNT & is_mnt), and instr[31]=1.
- Target ranks: every rank whose CS bit is low. Multiple low CS bits are a broadcast; each target rank updates identically.
- Decode from RAS/CAS/WE:
  - ACT = 0/1/1
  - PRE = 0/1/0; instr[10]=1 means precharge-all
  - RD = 1/0/1, WR = 1/0/0
  - REF = 0/0/1
  - Anything else leaves state unchanged.
- ACT on bank b: open<=1, row<=instr row, tRCD<=T_RCD, tRAS<=T_RAS, act_cnt+1 (saturating at all-ones). If b was already open, set err[0]; the state update still happens.
- PRE on bank b (or all banks when A10=1): open<=0, tRP<=T_RP. row<=instr row for single-bank PRE only; precharge-all keeps stored rows. PRE to an already-closed bank is legal and still reloads tRP.
- RD/WR to a closed bank sets err[1]; no state change.
- REF to a rank with any bank open sets err[2].
- All state updates take effect on the clk edge after a valid command; query outputs reflect the update on the next cycle.
- Countdowns: every nonzero countdown decrements by 1 each cycle; reload wins over decrement in the same cycle. T_* = 0 gives immediate readiness. T_* must fit in CNT_WIDTH; checked by elaboration assertion.
- cnt_clr: all ACT counters go to 0. If an ACT arrives in the same cycle, that bank's counter goes to 1.
- err_clr: all error flags clear. A new error in the same cycle wins, so its flag is set.
- is_app and is_mnt both high: one instr is processed once, not twice.
- Reset (rst=0, asynchronous): all banks closed, rows 0, countdowns 0, ACT counters 0, errors 0. Resulting outputs: maint_open=0, maint_row=0, maint_act_ok=1, maint_rdwr_ok=0, maint_pre_ok=1, maint_act_cnt=0.
- Reset asserted mid-countdown aborts the countdown immediately.
- Query outputs are purely combinational from registered state; out-of-range maint_rank (non-power-of-two CS_WIDTH) returns reset values.

Decomposition:
- Shared package / include holds:
  - command field offsets (CS/RAS/CAS/WE/A10)
  - command decode constants (ACT/PRE/RD/WR/REF encodings)
  - error bit indices
- One sub-module, bank_timer: a single bank's open bit, row, three countdowns and ACT counter, with load/clear inputs. Instantiated CS_WIDTH x NUM_BANKS times via generate. The top level holds decode, rank/bank demux, error logic and the query mux.

Test Plan:
- Reset, then ACT rank0 bank3 row 0x1234 -> next cycle maint_open=1, row=0x1234, rdwr_ok=0. rdwr_ok rises exactly 4 cycles later; pre_ok rises 10 cycles after the ACT; act_cnt=1.
- PRE bank3 row 0x0055 at cycle 12 -> open=0, row=0x0055, act_ok=0 for 4 cycles then 1. An ACT issued during the tRP window still updates state with no error.
- ACT bank3 twice -> protocol_err=3'b001 stays set until err_clr. Then RD to closed bank5 -> err=3'b010.
- Open banks 1, 4, 7, then PRE with A10=1 -> all banks closed, rows retained. REF -> no error. REF with bank 2 open -> err[2].
- ACT_CNT_WIDTH=4, 20 ACTs to bank0 -> count saturates at 15. cnt_clr together with an ACT -> count=1.
- CS_WIDTH=2 broadcast ACT (CS=2'b00) -> both ranks open. rst pulsed low mid-tRAS -> all outputs return to reset values asynchronously.
